// File: rtl/mem_access_pkg.sv
// Shared constants and types for the MEM-stage load/store controller.
// Opcodes, memory-port control codes, FSM states and the decoded access kind.
package mem_access_pkg;

    localparam logic [4:0] OP_LW_SP = 5'b10010;
    localparam logic [4:0] OP_LW    = 5'b10011;
    localparam logic [4:0] OP_SW_SP = 5'b11010;
    localparam logic [4:0] OP_SW    = 5'b11011;

    localparam logic [1:0] MEMCTL_IDLE  = 2'b00;
    localparam logic [1:0] MEMCTL_READ  = 2'b10;
    localparam logic [1:0] MEMCTL_WRITE = 2'b01;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    typedef enum logic [1:0] {
        KIND_NONE,
        KIND_LOAD,
        KIND_STORE
    } op_kind_t;

    function automatic logic [1:0] kind_to_memctl(op_kind_t kind);
        logic [1:0] code;
        code = MEMCTL_IDLE;
        case (kind)
            KIND_LOAD:  code = MEMCTL_READ;
            KIND_STORE: code = MEMCTL_WRITE;
            default:    code = MEMCTL_IDLE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Issue and memory-port bundle of the load/store controller.
// slave is the controller side, master is the pipeline/memory side.
interface mem_access_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [15:0]       instr_in;
    logic [ADDR_W-1:0] base_in;
    logic [DATA_W-1:0] wdata_in;
    logic              issue_valid;
    logic              issue_ready;
    logic [1:0]        mem_ctrl;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] rdata_out;
    logic              done;
    logic              fault;
    logic              is_io;
    logic              stall;

    modport slave (
        input  instr_in, base_in, wdata_in, issue_valid, mem_ack, mem_rdata,
        output issue_ready, mem_ctrl, mem_addr, mem_wdata, rdata_out,
        output done, fault, is_io, stall
    );

    modport master (
        output instr_in, base_in, wdata_in, issue_valid, mem_ack, mem_rdata,
        input  issue_ready, mem_ctrl, mem_addr, mem_wdata, rdata_out,
        input  done, fault, is_io, stall
    );

endinterface

// File: rtl/mem_addr_gen.sv
// Combinational decode of load/store opcodes and effective-address generation.
// Produces base + sign-extended offset (wrapping) and the IO-window hit flag.
module mem_addr_gen
    import mem_access_pkg::*;
#(
    parameter int                ADDR_W  = 16,
    parameter logic [ADDR_W-1:0] IO_BASE = 'hBF00,
    parameter logic [ADDR_W-1:0] IO_MASK = 'hFFF0
) (
    input  logic [15:0]       instr,
    input  logic [ADDR_W-1:0] base,
    output logic [ADDR_W-1:0] addr,
    output op_kind_t          kind,
    output logic              is_io
);

    logic [4:0]        opcode;
    logic [ADDR_W-1:0] ext;
    logic [2:0]        unused_instr;

    assign opcode       = instr[15:11];
    assign unused_instr = instr[10:8];

    // SP-relative forms carry an 8-bit offset, register forms a 5-bit one.
    always_comb begin
        kind = KIND_NONE;
        ext  = '0;
        case (opcode)
            OP_LW_SP: begin
                kind = KIND_LOAD;
                ext  = {{(ADDR_W-8){instr[7]}}, instr[7:0]};
            end
            OP_LW: begin
                kind = KIND_LOAD;
                ext  = {{(ADDR_W-5){instr[4]}}, instr[4:0]};
            end
            OP_SW_SP: begin
                kind = KIND_STORE;
                ext  = {{(ADDR_W-8){instr[7]}}, instr[7:0]};
            end
            OP_SW: begin
                kind = KIND_STORE;
                ext  = {{(ADDR_W-5){instr[4]}}, instr[4:0]};
            end
            default: begin
                kind = KIND_NONE;
                ext  = '0;
            end
        endcase
    end

    assign addr  = base + ext;
    assign is_io = ((addr & IO_MASK) == (IO_BASE & IO_MASK));

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: accepts one access at a time, drives a
// wait-state tolerant memory port with timeout abort, and stalls the pipeline.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | ready for issue; memory port idle (ctrl 00, addr all-ones)
//   ACCESS | access outstanding; port held stable until ack or timeout
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int                ADDR_W  = 16,
    parameter int                DATA_W  = 16,
    parameter int                TIMEOUT = 15,
    parameter logic [ADDR_W-1:0] IO_BASE = 'hBF00,
    parameter logic [ADDR_W-1:0] IO_MASK = 'hFFF0
) (
    input  logic        clk,
    input  logic        rst,
    mem_access_if.slave bus
);

    localparam int                CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(TIMEOUT - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [1:0]        ctrl_q, ctrl_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [DATA_W-1:0] wdata_q, wdata_nxt;
    logic [DATA_W-1:0] rdata_q, rdata_nxt;
    logic              io_q, io_nxt;
    logic              done_q, done_nxt;
    logic              fault_q, fault_nxt;

    logic [ADDR_W-1:0] gen_addr;
    op_kind_t          gen_kind;
    logic              gen_io;
    logic              ready;

    mem_addr_gen #(
        .ADDR_W  (ADDR_W),
        .IO_BASE (IO_BASE),
        .IO_MASK (IO_MASK)
    ) u_addr_gen (
        .instr (bus.instr_in),
        .base  (bus.base_in),
        .addr  (gen_addr),
        .kind  (gen_kind),
        .is_io (gen_io)
    );

    assign ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            ctrl_q  <= MEMCTL_IDLE;
            addr_q  <= '1;
            wdata_q <= '0;
            rdata_q <= '0;
            io_q    <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            ctrl_q  <= ctrl_nxt;
            addr_q  <= addr_nxt;
            wdata_q <= wdata_nxt;
            rdata_q <= rdata_nxt;
            io_q    <= io_nxt;
            done_q  <= done_nxt;
            fault_q <= fault_nxt;
        end
    end

    // Timeout is a down-counter loaded on accept; terminal count 0 without ack aborts.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ctrl_nxt  = ctrl_q;
        addr_nxt  = addr_q;
        wdata_nxt = wdata_q;
        rdata_nxt = rdata_q;
        io_nxt    = io_q;
        done_nxt  = 1'b0;
        fault_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (bus.issue_valid && (gen_kind != KIND_NONE)) begin
                    state_nxt = ACCESS;
                    cnt_nxt   = CNT_LOAD;
                    ctrl_nxt  = kind_to_memctl(gen_kind);
                    addr_nxt  = gen_addr;
                    wdata_nxt = bus.wdata_in;
                    io_nxt    = gen_io;
                end
            end
            ACCESS: begin
                if (bus.mem_ack) begin
                    state_nxt = IDLE;
                    ctrl_nxt  = MEMCTL_IDLE;
                    addr_nxt  = '1;
                    done_nxt  = 1'b1;
                    if (ctrl_q == MEMCTL_READ) begin
                        rdata_nxt = bus.mem_rdata;
                    end
                end else if (cnt == '0) begin
                    state_nxt = IDLE;
                    ctrl_nxt  = MEMCTL_IDLE;
                    addr_nxt  = '1;
                    done_nxt  = 1'b1;
                    fault_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.issue_ready = ready;
    assign bus.stall       = ~ready;
    assign bus.mem_ctrl    = ctrl_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.rdata_out   = rdata_q;
    assign bus.done        = done_q;
    assign bus.fault       = fault_q;
    assign bus.is_io       = io_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: table of single accesses plus
// hand-written sequences for timeout, IO/non-memory, reset abort and back-to-back issue.
module tb_mem_access_ctrl;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_access_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_access_ctrl #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (15),
        .IO_BASE (16'hBF00),
        .IO_MASK (16'hFFF0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] instr;
        logic [15:0] base;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          waits;
        logic [15:0] exp_addr;
        logic [1:0]  exp_ctrl;
        logic        exp_io;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs [6];
    int   tests  = 0;
    int   failed = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [15:0] instr, input logic [15:0] base, input logic [15:0] wdata);
        bus.instr_in    = instr;
        bus.base_in     = base;
        bus.wdata_in    = wdata;
        bus.issue_valid = 1'b1;
        step();
        bus.issue_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{16'h981F, 16'h1000, 16'h1111, 16'hA5A5, 0, 16'h0FFF, 2'b10, 1'b0, 16'hA5A5};
        vecs[1] = '{16'hD020, 16'hFFF0, 16'hBEEF, 16'h1234, 3, 16'h0010, 2'b01, 1'b0, 16'hA5A5};
        vecs[2] = '{16'h9801, 16'hBF00, 16'h2222, 16'h5A5A, 1, 16'hBF01, 2'b10, 1'b1, 16'h5A5A};
        vecs[3] = '{16'h9080, 16'h2000, 16'h3333, 16'hC3C3, 2, 16'h1F80, 2'b10, 1'b0, 16'hC3C3};
        vecs[4] = '{16'hD80F, 16'hBF00, 16'h7777, 16'h4444, 0, 16'hBF0F, 2'b01, 1'b1, 16'hC3C3};
        vecs[5] = '{16'hD808, 16'hBF08, 16'h8888, 16'h5555, 1, 16'hBF10, 2'b01, 1'b0, 16'hC3C3};

        rst             = 1'b1;
        bus.instr_in    = '0;
        bus.base_in     = '0;
        bus.wdata_in    = '0;
        bus.issue_valid = 1'b0;
        bus.mem_ack     = 1'b0;
        bus.mem_rdata   = '0;
        step();
        step();
        chk("rst_ctrl",  bus.mem_ctrl,    2'b00);
        chk("rst_addr",  bus.mem_addr,    16'hFFFF);
        chk("rst_wdata", bus.mem_wdata,   16'h0000);
        chk("rst_rdata", bus.rdata_out,   16'h0000);
        chk("rst_done",  {bus.done, bus.fault, bus.is_io}, 3'b000);
        chk("rst_ready", {bus.issue_ready, bus.stall}, 2'b10);
        rst = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            issue(vecs[i].instr, vecs[i].base, vecs[i].wdata);
            chk($sformatf("v%0d_ctrl", i),  bus.mem_ctrl,  vecs[i].exp_ctrl);
            chk($sformatf("v%0d_addr", i),  bus.mem_addr,  vecs[i].exp_addr);
            chk($sformatf("v%0d_wdata", i), bus.mem_wdata, vecs[i].wdata);
            chk($sformatf("v%0d_io", i),    bus.is_io,     vecs[i].exp_io);
            chk($sformatf("v%0d_stall", i), {bus.stall, bus.issue_ready, bus.done}, 3'b100);
            for (int w = 0; w < vecs[i].waits; w++) begin
                step();
                chk($sformatf("v%0d_wait%0d", i, w), {bus.mem_ctrl, bus.mem_addr, bus.done},
                    {vecs[i].exp_ctrl, vecs[i].exp_addr, 1'b0});
            end
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = vecs[i].rdata;
            step();
            bus.mem_ack   = 1'b0;
            chk($sformatf("v%0d_done", i),  {bus.done, bus.fault, bus.issue_ready}, 3'b101);
            chk($sformatf("v%0d_idle", i),  {bus.mem_ctrl, bus.mem_addr}, {2'b00, 16'hFFFF});
            chk($sformatf("v%0d_rdata", i), bus.rdata_out, vecs[i].exp_rdata);
            chk($sformatf("v%0d_io_hold", i), bus.is_io, vecs[i].exp_io);
            step();
            chk($sformatf("v%0d_pulse", i), {bus.done, bus.fault}, 2'b00);
        end

        // No ack: abort after 15 ACCESS cycles
        issue(16'h9800, 16'h0000, 16'h0000);
        chk("to_ctrl", bus.mem_ctrl, 2'b10);
        for (int k = 1; k < 15; k++) begin
            step();
            chk($sformatf("to_wait%0d", k), {bus.done, bus.fault, bus.mem_ctrl}, 4'b0010);
        end
        step();
        chk("to_done",  {bus.done, bus.fault}, 2'b11);
        chk("to_idle",  {bus.mem_ctrl, bus.mem_addr}, {2'b00, 16'hFFFF});
        chk("to_rdata", bus.rdata_out, 16'hC3C3);
        step();
        chk("to_pulse", {bus.done, bus.fault}, 2'b00);

        // Ack on the 15th cycle wins over timeout
        issue(16'h9800, 16'h0000, 16'h0000);
        for (int k = 1; k < 15; k++) step();
        chk("ack15_pre", bus.done, 1'b0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'h0F0F;
        step();
        bus.mem_ack   = 1'b0;
        chk("ack15_done",  {bus.done, bus.fault}, 2'b10);
        chk("ack15_rdata", bus.rdata_out, 16'h0F0F);
        step();

        // IO hit, then non-memory opcode and stray ack in IDLE change nothing
        issue(16'h9801, 16'hBF00, 16'h0000);
        chk("io_hit", bus.is_io, 1'b1);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'h6666;
        step();
        bus.mem_ack   = 1'b0;
        chk("io_rdata", bus.rdata_out, 16'h6666);
        step();
        issue(16'h0800, 16'h1234, 16'h9999);
        chk("nomem_ctrl",  {bus.mem_ctrl, bus.mem_addr}, {2'b00, 16'hFFFF});
        chk("nomem_done",  {bus.done, bus.issue_ready, bus.is_io}, 3'b011);
        chk("nomem_wdata", bus.mem_wdata, 16'h0000);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'hDEAD;
        step();
        bus.mem_ack   = 1'b0;
        chk("idle_ack", {bus.done, bus.rdata_out}, {1'b0, 16'h6666});

        // Reset mid-access aborts silently
        issue(16'hD80F, 16'hBF00, 16'hABCD);
        chk("ra_ctrl", bus.mem_ctrl, 2'b01);
        rst = 1'b1;
        step();
        chk("ra_ctrl_rst", {bus.mem_ctrl, bus.mem_addr}, {2'b00, 16'hFFFF});
        chk("ra_regs", {bus.mem_wdata, bus.rdata_out}, 32'h0);
        chk("ra_flags", {bus.done, bus.fault, bus.is_io, bus.issue_ready}, 4'b0001);
        rst = 1'b0;
        step();
        chk("ra_after", bus.done, 1'b0);

        // Back-to-back issue in the done cycle
        issue(16'h981F, 16'h1000, 16'h0000);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'h1357;
        step();
        bus.mem_ack   = 1'b0;
        chk("b2b_done", {bus.done, bus.issue_ready}, 2'b11);
        issue(16'hD020, 16'hFFF0, 16'h2468);
        chk("b2b_ctrl",  {bus.mem_ctrl, bus.mem_addr}, {2'b01, 16'h0010});
        chk("b2b_wdata", {bus.mem_wdata, bus.done}, {16'h2468, 1'b0});
        chk("b2b_rdata", bus.rdata_out, 16'h1357);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
